// File: rtl/apb_cmd_master.sv
// APB master: turns one valid/ready command into one APB transfer and returns
// a valid/ready response carrying read data, slave error and timeout status.
module apb_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_LIM_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(CNT_LIM_I);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  // S_LOAD is the cycle after the command handshake; bus outputs follow the
  // state by one edge, so PSEL=1 coincides with S_SETUP and PENABLE=1 with S_ACCESS.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_timeout_hit;

  assign w_timeout_hit = TO_EN && (r_cnt == CNT_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      cmd_rdy     <= 1'b1;
      busy        <= 1'b0;
      rsp_vld     <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_vld) begin
            r_wr    <= cmd_wr;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            cmd_rdy <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          PSEL    <= 1'b1;
          PENABLE <= 1'b0;
          PWRITE  <= r_wr;
          PADDR   <= r_addr;
          PWDATA  <= r_wr ? r_wdata : '0;
          r_state <= S_SETUP;
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          // PREADY takes priority over a timeout landing in the same cycle
          if (PREADY) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_vld     <= 1'b1;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!r_wr && !PSLVERR) ? PRDATA : '0;
            r_state     <= S_RESP;
          end else if (w_timeout_hit) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_vld     <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            cmd_rdy <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          rsp_vld <= 1'b0;
          cmd_rdy <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed vector table, randomized
// transfers against a transaction-level model, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_apb_cmd_master;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_vld, cmd_rdy, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_vld, rsp_rdy, rsp_err, rsp_timeout, busy;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  always #5 clk = ~clk;

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // waits = ACCESS cycles the slave spends with PREADY low before raising it
  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    bit          slverr;
    int          rdly;
    bit          exp_err;
    bit          exp_to;
    logic [31:0] exp_rdata;
    int          exp_acc;
  } vec_t;

  function automatic vec_t mk(input bit wr, input logic [63:0] addr, input logic [31:0] wdata,
                              input int waits, input logic [31:0] prdata, input bit slverr,
                              input int rdly, input bit e_err, input bit e_to,
                              input logic [31:0] e_rdata, input int e_acc);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits; v.prdata = prdata;
    v.slverr = slverr; v.rdly = rdly; v.exp_err = e_err; v.exp_to = e_to;
    v.exp_rdata = e_rdata; v.exp_acc = e_acc;
    return v;
  endfunction

  // Transaction-level model: a slave that stays silent for TO cycles causes a timeout
  function automatic vec_t ref_model(input vec_t v);
    vec_t r = v;
    bit timed_out = (v.waits >= int'(TO));
    r.exp_acc   = timed_out ? int'(TO) : v.waits + 1;
    r.exp_to    = timed_out;
    r.exp_err   = timed_out || v.slverr;
    r.exp_rdata = (timed_out || v.wr || v.slverr) ? 32'h0 : v.prdata;
    return r;
  endfunction

  // Runs one transfer; called right after a negedge, returns right after a negedge.
  task automatic run_xfer(input vec_t v, input string tag);
    int n, psel_n, pen_n, acc, rsp_n, lat;
    bit done, hs, bus_bad, rsp_bad;
    cmd_vld = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; rsp_rdy = 1'b0;
    n = 0;
    while (!cmd_rdy && n < 20) begin @(negedge clk); n++; end
    chk({tag, " cmd_rdy"}, 64'(cmd_rdy), 64'd1);
    @(negedge clk);
    // scramble the command bus so only the latched copy can be used
    cmd_vld = 1'b0; cmd_wr = ~v.wr; cmd_addr = {$urandom, $urandom}; cmd_wdata = $urandom;
    chk({tag, " busy"}, 64'({busy, cmd_rdy}), 64'b10);
    n = 1; psel_n = 0; pen_n = 0; acc = 0; rsp_n = 0; lat = 0;
    done = 0; hs = 0; bus_bad = 0; rsp_bad = 0;
    while (!done && n < 60) begin
      if (PSEL) begin
        psel_n++;
        if (PADDR !== v.addr || PWRITE !== v.wr || PWDATA !== (v.wr ? v.wdata : 32'h0))
          bus_bad = 1;
      end
      if (PSEL && rsp_vld) bus_bad = 1;
      if (PSEL && PENABLE) begin
        pen_n++;
        PREADY  = (acc == v.waits);
        PRDATA  = PREADY ? v.prdata : $urandom;
        PSLVERR = PREADY ? v.slverr : 1'($urandom);
        acc++;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b0;
      end
      if (rsp_vld) begin
        if (rsp_n == 0) begin
          lat = n;
          chk({tag, " rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
          chk({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'(v.exp_to));
          chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        end else if (rsp_err !== v.exp_err || rsp_timeout !== v.exp_to ||
                     rsp_rdata !== v.exp_rdata) begin
          rsp_bad = 1;
        end
        rsp_rdy = (rsp_n >= v.rdly);
        hs = rsp_rdy;
        rsp_n++;
      end
      @(negedge clk);
      n++;
      if (hs) done = 1;
    end
    rsp_rdy = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    chk({tag, " handshake"}, 64'(done), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(3 + v.exp_acc));
    chk({tag, " psel cycles"}, 64'(psel_n), 64'(v.exp_acc + 1));
    chk({tag, " penable cycles"}, 64'(pen_n), 64'(v.exp_acc));
    chk({tag, " bus stable"}, 64'(bus_bad), 64'd0);
    chk({tag, " rsp stable"}, 64'(rsp_bad), 64'd0);
    chk({tag, " rsp hold"}, 64'(rsp_n), 64'(v.rdly + 1));
    chk({tag, " back to idle"}, 64'({rsp_vld, cmd_rdy, busy}), 64'b010);
  endtask

  vec_t tbl[7];
  vec_t cq[3];
  logic [31:0] exp_q[3];

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_rdy = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    chk("reset ctrl", 64'({cmd_rdy, busy, rsp_vld, PSEL, PENABLE, PWRITE}), 64'b100000);
    chk("reset rsp", 64'({rsp_err, rsp_timeout, rsp_rdata}), 64'd0);
    chk("reset paddr", PADDR, 64'd0);
    chk("reset pwdata", 64'(PWDATA), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed vectors: wr, addr, wdata, waits, prdata, slverr, rdly | err, to, rdata, acc
    tbl[0] = mk(1, 64'h0,  32'h12345678, 0, 32'hFFFF0000, 0, 0, 0, 0, 32'h0, 1);
    tbl[1] = mk(0, 64'h4,  32'h0,        3, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 4);
    tbl[2] = mk(0, 64'h8,  32'h0,        0, 32'hCAFEF00D, 1, 0, 1, 0, 32'h0, 1);
    tbl[3] = mk(0, 64'h10, 32'h0,        9, 32'h11111111, 0, 0, 1, 1, 32'h0, 4);
    tbl[4] = mk(1, 64'h20, 32'hA5A5A5A5, 1, 32'h22222222, 0, 3, 0, 0, 32'h0, 2);
    tbl[5] = mk(1, 64'h24, 32'h5A5A5A5A, 2, 32'h33333333, 1, 1, 1, 0, 32'h0, 3);
    tbl[6] = mk(0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 2, 32'h0BADF00D, 0, 2, 0, 0, 32'h0BADF00D, 3);
    for (int i = 0; i < 7; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

    // randomized transfers against the model
    for (int i = 0; i < 30; i++) begin
      vec_t v;
      v.wr = 1'($urandom); v.addr = {$urandom, $urandom}; v.wdata = $urandom;
      v.waits = int'($urandom_range(0, 6)); v.prdata = $urandom;
      v.slverr = ($urandom_range(0, 3) == 0); v.rdly = int'($urandom_range(0, 3));
      run_xfer(ref_model(v), $sformatf("rnd%0d", i));
    end

    // reset in the 2nd ACCESS cycle of a read: transfer dropped, no response
    begin
      int n = 0, pen = 0;
      bit stray = 0;
      cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 64'h40; cmd_wdata = '0;
      @(negedge clk);
      cmd_vld = 1'b0;
      while (pen < 2 && n < 20) begin
        @(negedge clk); n++;
        if (PSEL && PENABLE) pen++;
      end
      chk("rst seq reached access", 64'(pen), 64'd2);
      rst = 1'b1;
      @(negedge clk);
      chk("rst seq outputs", 64'({PSEL, PENABLE, rsp_vld, busy, cmd_rdy}), 64'b00001);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (rsp_vld || PSEL) stray = 1;
      end
      chk("rst seq no response", 64'(stray), 64'd0);
      chk("rst seq cmd_rdy", 64'(cmd_rdy), 64'd1);
    end

    // three back-to-back commands with cmd_vld held high, first response stalled 5 cycles
    begin
      int idx = 0, rcv = 0, stall = 0, rises = 0;
      bit prev_psel = 0, will_hs = 0, bad = 0;
      cq[0] = mk(1, 64'h100, 32'h01020304, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1);
      cq[1] = mk(0, 64'h104, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1);
      cq[2] = mk(0, 64'h108, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1);
      exp_q[0] = 32'h0;
      exp_q[1] = 32'h5A5A0104;
      exp_q[2] = 32'h5A5A0108;
      cmd_vld = 1'b1; cmd_wr = cq[0].wr; cmd_addr = cq[0].addr; cmd_wdata = cq[0].wdata;
      will_hs = cmd_rdy;
      for (int c = 0; c < 200 && rcv < 3; c++) begin
        @(negedge clk);
        if (will_hs) begin
          idx++;
          if (idx < 3) begin
            cmd_wr = cq[idx].wr; cmd_addr = cq[idx].addr; cmd_wdata = cq[idx].wdata;
          end else cmd_vld = 1'b0;
        end
        if (PSEL && !prev_psel) rises++;
        if (rises > rcv + 1 || (PSEL && rsp_vld)) bad = 1;
        prev_psel = PSEL;
        PREADY  = PSEL && PENABLE;
        PRDATA  = PADDR[31:0] ^ 32'h5A5A0000;
        PSLVERR = 1'b0;
        if (rsp_vld) begin
          if (rcv == 0 && stall < 5) begin rsp_rdy = 1'b0; stall++; end
          else rsp_rdy = 1'b1;
          if (rsp_rdy) begin
            chk($sformatf("b2b rsp%0d rdata", rcv), 64'(rsp_rdata), 64'(exp_q[rcv]));
            rcv++;
          end
        end else rsp_rdy = 1'b0;
        will_hs = cmd_vld && cmd_rdy;
      end
      @(negedge clk);
      rsp_rdy = 1'b0; PREADY = 1'b0;
      chk("b2b responses", 64'(rcv), 64'd3);
      chk("b2b stall cycles", 64'(stall), 64'd5);
      chk("b2b psel spacing", 64'(bad), 64'd0);
      chk("b2b psel count", 64'(rises), 64'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
